wwcrouch_sprite_fetch: RTL

- Pixel-fetch stage directly upstream of the crouch-sprite palette lookup.
- Takes VGA draw coordinates and the character position, and sequences the crouch animation frames from the frame tick.
- Drives the sprite ROM address and registers the returned 4-bit colour index.
- Delivers index plus an opaque-pixel flag, aligned to a fixed pipeline latency, for the palette stage and the colour mapper.

---
 rtl/wwcrouch_sprite_fetch_if.sv | 34 +++
 rtl/wwcrouch_sprite_fetch.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wwcrouch_sprite_fetch_if.sv
// Bus bundle for the crouch-sprite fetch stage.
// Carries draw/position coordinates, animation control, sprite ROM address/data,
// and the palette-side results.
// The master side is the environment: the VGA controller, the game logic and the ROM.
// The slave side is the fetch stage itself.
interface wwcrouch_sprite_fetch_if #(
  parameter int unsigned ADDR_W = 13
);
  logic              frame_clk;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [9:0]        PosX;
  logic [9:0]        PosY;
  logic              crouch_req;
  logic              facing_left;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_q;
  logic [3:0]        palette_index;
  logic              pix_on;
  logic [1:0]        anim_frame;
  logic              crouching;

  // Environment side: drives coordinates and requests, and returns ROM data
  modport master (
    output frame_clk, DrawX, DrawY, PosX, PosY, crouch_req, facing_left, rom_q,
    input  rom_addr, palette_index, pix_on, anim_frame, crouching
  );

  // Fetch-stage side
  modport slave (
    input  frame_clk, DrawX, DrawY, PosX, PosY, crouch_req, facing_left, rom_q,
    output rom_addr, palette_index, pix_on, anim_frame, crouching
  );
endinterface

// File: rtl/wwcrouch_sprite_fetch.sv
// Crouch-sprite pixel fetch stage.
// The stage sequences the crouch animation frames from frame_clk ticks.
// It runs the sprite hit test on the current draw coordinate and drives the sprite ROM address.
// It returns the palette index and the opaque flag with a fixed latency of ROM_LAT+2 cycles.
// Optional feature: define WWCROUCH_FLIP_EN to enable horizontal mirroring via facing_left.
// Without that macro, facing_left is ignored.
module wwcrouch_sprite_fetch #(
  parameter int unsigned SPR_W           = 48,
  parameter int unsigned SPR_H           = 40,
  parameter int unsigned NUM_FRAMES      = 3,
  parameter int unsigned FRAME_TICKS     = 4,
  parameter int unsigned ROM_LAT         = 1,
  parameter int unsigned TRANSPARENT_IDX = 0
) (
  input logic                    Clk,
  input logic                    Reset,
  wwcrouch_sprite_fetch_if.slave bus
);

  localparam int unsigned FRAME_PIX  = SPR_W * SPR_H;
  localparam int unsigned ADDR_W     = $clog2(NUM_FRAMES * FRAME_PIX);
  localparam int unsigned TICK_W     = $clog2(FRAME_TICKS + 1);
  localparam int unsigned LAST_FRAME = NUM_FRAMES - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    HOLD = 2'd2,
    UP   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [TICK_W-1:0]   tick_cnt;
  logic [TICK_W-1:0]   tick_cnt_nxt;
  logic [1:0]          frame;
  logic [1:0]          frame_nxt;
  logic                crouching_q;
  logic                crouching_nxt;

  logic                frame_clk_q;
  logic                tick;
  logic                step;

  logic                hit;
  logic [9:0]          dx;
  logic [9:0]          dy;
  logic [9:0]          col;
  logic [ADDR_W-1:0]   addr;

  logic [ADDR_W-1:0]   rom_addr_q;
  logic [ROM_LAT:0]    hit_pipe;
  logic                hit_d;
  logic [3:0]          palette_q;
  logic                pix_on_q;

  // Edge detector for the vsync-derived frame clock
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) frame_clk_q <= 1'b0;
    else       frame_clk_q <= bus.frame_clk;
  end

  assign tick = bus.frame_clk & ~frame_clk_q;
  assign step = tick && (tick_cnt == TICK_W'(FRAME_TICKS - 1));

  // Animation state register (state, tick counter, frame and crouch flag)
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      frame       <= 2'd0;
      crouching_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      tick_cnt    <= tick_cnt_nxt;
      frame       <= frame_nxt;
      crouching_q <= crouching_nxt;
    end
  end

  // Next-state logic. A reversal continues from the current frame.
  // The boundary guards keep the frame inside 0..NUM_FRAMES-1.
  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    frame_nxt    = frame;
    unique case (state)
      IDLE: begin
        frame_nxt = 2'd0;
        if (bus.crouch_req) begin
          state_nxt    = DOWN;
          tick_cnt_nxt = '0;
        end
      end
      DOWN: begin
        if (!bus.crouch_req) begin
          state_nxt    = UP;
          tick_cnt_nxt = '0;
        end else if (frame >= 2'(LAST_FRAME)) begin
          state_nxt = HOLD;
        end else if (tick) begin
          if (step) begin
            tick_cnt_nxt = '0;
            frame_nxt    = frame + 2'd1;
            if (frame + 2'd1 == 2'(LAST_FRAME)) state_nxt = HOLD;
          end else begin
            tick_cnt_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end
      HOLD: begin
        if (!bus.crouch_req) begin
          state_nxt    = UP;
          tick_cnt_nxt = '0;
        end
      end
      UP: begin
        if (bus.crouch_req) begin
          state_nxt    = DOWN;
          tick_cnt_nxt = '0;
        end else if (frame == 2'd0) begin
          state_nxt = IDLE;
        end else if (tick) begin
          if (step) begin
            tick_cnt_nxt = '0;
            frame_nxt    = frame - 2'd1;
            if (frame == 2'd1) state_nxt = IDLE;
          end else begin
            tick_cnt_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        tick_cnt_nxt = '0;
        frame_nxt    = 2'd0;
      end
    endcase
  end

  // Output decode: the crouch flag tracks the HOLD state
  always_comb begin
    crouching_nxt = 1'b0;
    if (state_nxt == HOLD) crouching_nxt = 1'b1;
  end

  // Hit test in 11-bit arithmetic so that the sprite extents never wrap.
  // The ROM address is built from the frame, the sprite row and the (optionally mirrored) column.
  always_comb begin
    hit = ({1'b0, bus.DrawX} >= {1'b0, bus.PosX}) &&
          ({1'b0, bus.DrawX} <  ({1'b0, bus.PosX} + 11'(SPR_W))) &&
          ({1'b0, bus.DrawY} >= {1'b0, bus.PosY}) &&
          ({1'b0, bus.DrawY} <  ({1'b0, bus.PosY} + 11'(SPR_H)));
    dx  = bus.DrawX - bus.PosX;
    dy  = bus.DrawY - bus.PosY;
`ifdef WWCROUCH_FLIP_EN
    col = bus.facing_left ? (10'(SPR_W - 1) - dx) : dx;
`else
    col = dx;
`endif
    addr = ADDR_W'(frame) * ADDR_W'(FRAME_PIX) +
           ADDR_W'(dy) * ADDR_W'(SPR_W) +
           ADDR_W'(col);
  end

`ifndef WWCROUCH_FLIP_EN
  logic unused_facing_left;
  assign unused_facing_left = bus.facing_left;
`endif

  // Address stage, plus the hit delay line that matches the ROM read latency
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr_q <= '0;
      hit_pipe   <= '0;
    end else begin
      rom_addr_q  <= hit ? addr : '0;
      hit_pipe[0] <= hit;
      for (int i = 1; i <= int'(ROM_LAT); i++) hit_pipe[i] <= hit_pipe[i-1];
    end
  end

  assign hit_d = hit_pipe[ROM_LAT];

  // Output stage: register the returned colour index and the opaque flag
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      palette_q <= 4'd0;
      pix_on_q  <= 1'b0;
    end else begin
      palette_q <= hit_d ? bus.rom_q : 4'd0;
      pix_on_q  <= hit_d && (bus.rom_q != 4'(TRANSPARENT_IDX));
    end
  end

  assign bus.rom_addr      = rom_addr_q;
  assign bus.palette_index = palette_q;
  assign bus.pix_on        = pix_on_q;
  assign bus.anim_frame    = frame;
  assign bus.crouching     = crouching_q;

endmodule
